// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and a
// constant-foldable ceil(log2) helper usable by both TX and RX blocks.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level.
// Pushes while full and pops while empty are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [clog2(DEPTH):0]  level_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q,  level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LEVEL_FULL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointer and level next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; the level counter alone decides which entries are valid.
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a sync_fifo feeds a start/data/parity/stop
// serialiser that chains frames back-to-back while words are queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 9600,
    parameter int NR_OF_DATA_BITS = 8,
    parameter int PARITY_MODE     = 0,
    parameter int NR_OF_STOP_BITS = 1,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NR_OF_DATA_BITS-1:0]  data,
    input  logic                        dataValid,
    output logic                        dataReady,
    output logic [clog2(FIFO_DEPTH):0]  fifoLevel,
    output logic                        busy,
    output logic                        tx
);

    localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int BAUD_W         = clog2(CLOCKS_PER_BIT);
    localparam int BIT_W          = clog2(NR_OF_DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(NR_OF_DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(NR_OF_STOP_BITS - 1);

    if (CLOCKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_buffered: CLOCK_FREQUENCY/BAUD_RATE must be >= 2");
    end
    if (NR_OF_DATA_BITS < 5 || NR_OF_DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_buffered: NR_OF_DATA_BITS must be 5..9");
    end
    if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
        PARITY_MODE != PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_buffered: PARITY_MODE must be 0, 1 or 2");
    end
    if (NR_OF_STOP_BITS < 1 || NR_OF_STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_buffered: NR_OF_STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_e                state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [NR_OF_DATA_BITS-1:0] shift_q, shift_d;
    logic                       parity_q, parity_d;
    logic                       tx_q, tx_d;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic [NR_OF_DATA_BITS-1:0] fifo_rdata;
    logic                       baud_end;
    logic                       load;

    sync_fifo #(
        .WIDTH (NR_OF_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (dataValid),
        .data_i  (data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifoLevel)
    );

    assign dataReady = ~fifo_full;
    assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
    assign tx        = tx_q;
    assign baud_end  = (baud_q == BAUD_LAST);

    // Next-state logic: bit sequencing, baud timing and FIFO pop for the next frame.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        load     = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                load = ~fifo_empty;
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_MODE != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        // Chain directly into the next start bit when data is waiting.
                        load    = ~fifo_empty;
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d  = ST_START;
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = fifo_rdata;
            parity_d = (PARITY_MODE == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
            tx_d     = 1'b0;
        end
        fifo_pop = load;
    end

    // Serialiser state register; reset forces the line idle on the same edge.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: four configurations at 10 clocks/bit,
// expected words queued on push and popped when a frame appears on tx.
module tb_uart_tx_buffered;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [3:0]      reset_v;
    logic [3:0]      valid_v;
    logic [3:0]      ready_v;
    logic [3:0]      busy_v;
    logic [3:0]      tx_v;
    logic [3:0][3:0] level_v;
    logic [7:0]      data_a, data_b, data_c;
    logic [4:0]      data_d;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] words [10];
    int         waited;
    logic       busy_last;
    int         acc;
    int         stall_acc;
    logic [3:0] stall_lvl;
    logic       will;

    // 8N1, depth 8
    uart_tx_buffered #(.CLOCK_FREQUENCY(10), .BAUD_RATE(1), .NR_OF_DATA_BITS(8),
                       .PARITY_MODE(0), .NR_OF_STOP_BITS(1), .FIFO_DEPTH(8)) u_a (
        .clock(clock), .reset(reset_v[0]), .data(data_a), .dataValid(valid_v[0]),
        .dataReady(ready_v[0]), .fifoLevel(level_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
    // 8E2
    uart_tx_buffered #(.CLOCK_FREQUENCY(10), .BAUD_RATE(1), .NR_OF_DATA_BITS(8),
                       .PARITY_MODE(1), .NR_OF_STOP_BITS(2), .FIFO_DEPTH(8)) u_b (
        .clock(clock), .reset(reset_v[1]), .data(data_b), .dataValid(valid_v[1]),
        .dataReady(ready_v[1]), .fifoLevel(level_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
    // 8O1
    uart_tx_buffered #(.CLOCK_FREQUENCY(10), .BAUD_RATE(1), .NR_OF_DATA_BITS(8),
                       .PARITY_MODE(2), .NR_OF_STOP_BITS(1), .FIFO_DEPTH(8)) u_c (
        .clock(clock), .reset(reset_v[2]), .data(data_c), .dataValid(valid_v[2]),
        .dataReady(ready_v[2]), .fifoLevel(level_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
    // 5N1
    uart_tx_buffered #(.CLOCK_FREQUENCY(10), .BAUD_RATE(1), .NR_OF_DATA_BITS(5),
                       .PARITY_MODE(0), .NR_OF_STOP_BITS(1), .FIFO_DEPTH(8)) u_d (
        .clock(clock), .reset(reset_v[3]), .data(data_d), .dataValid(valid_v[3]),
        .dataReady(ready_v[3]), .fifoLevel(level_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic [7:0] w, input logic v);
        case (k)
            0: data_a = w;
            1: data_b = w;
            2: data_c = w;
            3: data_d = w[4:0];
            default: ;
        endcase
        valid_v[k] = v;
    endtask

    // One handshake; returns at the falling edge after the accepting edge.
    task automatic push_one(input int k, input logic [7:0] w, input logic record);
        int n;
        @(negedge clock);
        drive(k, w, 1'b1);
        n = 0;
        while (ready_v[k] !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("push%0d_ready", k), 16'(ready_v[k]), 16'd1);
        @(posedge clock);
        if (record) exp_q.push_back(w);
        @(negedge clock);
        drive(k, w, 1'b0);
    endtask

    // Waits for a start bit, then checks every cycle of every bit against the popped word.
    task automatic check_frame(input int k, input int ndb, input int pm, input int nsb,
                               input string tag, output int wait_cycles, output logic busy_end);
        logic [15:0] bits;
        logic [7:0]  w;
        logic        p;
        logic        got;
        int          nb;
        wait_cycles = 0;
        busy_end    = 1'b0;
        while (tx_v[k] !== 1'b0 && wait_cycles < 400) begin
            @(negedge clock);
            wait_cycles++;
        end
        check({tag, "_start_seen"}, 16'(tx_v[k]), 16'd0);
        w = 8'h00;
        if (exp_q.size() > 0) w = exp_q.pop_front();
        else check({tag, "_queue_empty"}, 16'd0, 16'd1);
        bits = '0;
        nb = 0;
        p = 1'b0;
        bits[nb] = 1'b0;
        nb++;
        for (int i = 0; i < ndb; i++) begin
            bits[nb] = w[i];
            p = p ^ w[i];
            nb++;
        end
        if (pm != 0) begin
            bits[nb] = (pm == 2) ? ~p : p;
            nb++;
        end
        for (int i = 0; i < nsb; i++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            got = bits[b];
            for (int c = 0; c < 10; c++) begin
                if (tx_v[k] !== bits[b]) got = tx_v[k];
                busy_end = busy_v[k];
                @(negedge clock);
            end
            check($sformatf("%s_bit%0d", tag, b), 16'(got), 16'(bits[b]));
        end
    endtask

    task automatic frame_done(input int k, input string tag, input logic busy_end);
        check({tag, "_busy_last_stop"}, 16'(busy_end), 16'd1);
        check({tag, "_busy_after"}, 16'(busy_v[k]), 16'd0);
        check({tag, "_tx_idle"}, 16'(tx_v[k]), 16'd1);
    endtask

    initial begin
        words = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'hF0, 8'h0F, 8'h69, 8'h96};
        reset_v = 4'b0000;
        valid_v = 4'b0000;
        data_a = '0;
        data_b = '0;
        data_c = '0;
        data_d = '0;

        // 1. reset state of every configuration
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst%0d_tx", k), 16'(tx_v[k]), 16'd1);
            check($sformatf("rst%0d_busy", k), 16'(busy_v[k]), 16'd0);
            check($sformatf("rst%0d_ready", k), 16'(ready_v[k]), 16'd1);
            check($sformatf("rst%0d_level", k), 16'(level_v[k]), 16'd0);
        end
        reset_v = 4'b1111;

        // 2. 8N1 single frame with latency and busy timing
        push_one(0, 8'hA5, 1'b1);
        check("a5_busy_on_push", 16'(busy_v[0]), 16'd1);
        check("a5_tx_before", 16'(tx_v[0]), 16'd1);
        check("a5_level_after_push", 16'(level_v[0]), 16'd1);
        check_frame(0, 8, 0, 1, "a5", waited, busy_last);
        check("a5_latency", 16'(waited), 16'd1);
        frame_done(0, "a5", busy_last);

        // 3. parity and stop-bit variants
        push_one(1, 8'h07, 1'b1);
        check_frame(1, 8, 1, 2, "even2", waited, busy_last);
        frame_done(1, "even2", busy_last);
        push_one(2, 8'h07, 1'b1);
        check_frame(2, 8, 2, 1, "odd", waited, busy_last);
        frame_done(2, "odd", busy_last);

        // 4. continuous producer fills the FIFO; frames must chain without gaps
        stall_acc = -1;
        stall_lvl = '0;
        fork
            begin
                acc = 0;
                drive(0, words[0], 1'b1);
                for (int cyc = 0; cyc < 400 && acc < 10; cyc++) begin
                    will = ready_v[0];
                    @(posedge clock);
                    if (will) begin
                        exp_q.push_back(words[acc]);
                        acc++;
                    end
                    @(negedge clock);
                    if (acc < 10) drive(0, words[acc], 1'b1);
                    else drive(0, 8'h00, 1'b0);
                    if (ready_v[0] !== 1'b1 && stall_acc < 0) begin
                        stall_acc = acc;
                        stall_lvl = level_v[0];
                    end
                end
                drive(0, 8'h00, 1'b0);
            end
            begin
                for (int f = 0; f < 10; f++) begin
                    check_frame(0, 8, 0, 1, $sformatf("burst%0d", f), waited, busy_last);
                    if (f > 0) check($sformatf("burst%0d_gap", f), 16'(waited), 16'd0);
                end
            end
        join
        check("burst_accepted_at_full", 16'(stall_acc), 16'd9);
        check("burst_level_at_full", 16'(stall_lvl), 16'd8);
        check("burst_total_accepted", 16'(acc), 16'd10);
        frame_done(0, "burst", busy_last);

        // 5. reset in the middle of data bit 3 with three words queued
        push_one(0, 8'h00, 1'b0);
        push_one(0, 8'hFF, 1'b0);
        push_one(0, 8'h55, 1'b0);
        push_one(0, 8'hAA, 1'b0);
        check("abort_level_queued", 16'(level_v[0]), 16'd3);
        repeat (39) @(negedge clock);
        check("abort_tx_bit3_low", 16'(tx_v[0]), 16'd0);
        reset_v[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort_tx", 16'(tx_v[0]), 16'd1);
        check("abort_level", 16'(level_v[0]), 16'd0);
        check("abort_busy", 16'(busy_v[0]), 16'd0);
        check("abort_ready", 16'(ready_v[0]), 16'd1);
        reset_v[0] = 1'b1;
        push_one(0, 8'h3C, 1'b1);
        check_frame(0, 8, 0, 1, "after_abort", waited, busy_last);
        check("after_abort_latency", 16'(waited), 16'd1);
        frame_done(0, "after_abort", busy_last);

        // 6. five data bits
        push_one(3, 8'h13, 1'b1);
        check_frame(3, 5, 0, 1, "five", waited, busy_last);
        frame_done(3, "five", busy_last);
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
